cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Multi-cycle control FSM for the single-issue RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file and data memory.
- Drives the instruction/data memory request handshakes, the IR latch, the PC update and the register-file write strobe.
- Parks the core on a halt instruction or a bus timeout.

Parameters:
- CNT_W, 32: width of the performance counters and the timeout counter.
- TIMEOUT, 0: maximum cycles to wait for imem_ack/dmem_ack; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- ir_we  out  1  latch fetched word into IR
- dec_reg_we  in  1  decoder: instruction writes rd
- dec_is_load  in  1  decoder: load
- dec_is_store  in  1  decoder: store
- dec_is_halt  in  1  decoder: halt
- br_taken  in  1  branch/jump redirect from ALU
- pc_we  out  1  PC update strobe
- pc_sel  out  1  0 = PC+4, 1 = ALU target
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write strobe
- halted  out  1  core parked in HALT
- bus_err  out  1  halt was caused by a timeout
- state  out  3  current state (debug)

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high: rst sampled high at a clk edge loads state = FETCH and clears the timeout counter, bus_err and the perf counters.
- All outputs except bus_err are combinational decodes of the state register and are forced to 0 while rst is high.
- Reset applied mid-operation (for example in MEM with dmem_req high) drops every request combinationally. Fetch restarts the cycle after rst deasserts.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6–7 are illegal and transition to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_we=1 in the same cycle, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - One cycle while the decoder outputs settle.
  - dec_is_halt → HALT, else → EXEC.
- EXEC:
  - One cycle of ALU evaluation.
  - dec_is_load or dec_is_store → MEM, else → WB.
- MEM:
  - dmem_req=1, dmem_we=dec_is_store.
  - Hold until dmem_ack, then → WB.
  - Request and we stay stable while waiting.
- WB:
  - rf_we=dec_reg_we, pc_we=1, pc_sel=br_taken.
  - Next state FETCH.
  - Stores reach WB with dec_reg_we=0, so no register write occurs.
- HALT:
  - halted=1; all strobes 0.
  - Sticky until rst.
- Latency with zero-wait memories:
  - ALU/branch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- Each memory wait cycle adds one cycle.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- pc_we and rf_we assert for exactly one cycle per retired instruction.
- Timeout (TIMEOUT>0):
  - The counter increments on each FETCH/MEM cycle without ack and clears on ack or on a state change.
  - When the count reaches TIMEOUT-1 with no ack, next state is HALT and bus_err is set. bus_err is registered and cleared only by rst.
- Timeout (TIMEOUT=0): never halts on a missing ack.

Optional Feature:
- Macro CPU_SEQ_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0].
  - cycle_cnt increments every non-reset cycle outside HALT.
  - instret_cnt increments on each WB cycle.
  - Both wrap modulo 2^CNT_W and freeze in HALT.
- When undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: the state encodings (SEQ_FETCH … SEQ_HALT), state width 3, and the PC_SEL_SEQ/PC_SEL_TGT constants go into the core's common define include, next to the existing ENABLE/DISABLE and ALU codes.
- Optional sub-module: seq_timeout, which holds the wait counter and compare and outputs a single expired flag.
- All other logic stays in one FSM module.

Test Plan:
- Reset, then an ADDI word with imem_ack on the first FETCH cycle → state sequence 0,1,2,4,0. ir_we pulses in cycle 0; rf_we=1 and pc_we=1 with pc_sel=0 in cycle 3.
- LW with dmem_ack delayed 3 cycles → dmem_req high for 4 cycles with dmem_we=0. rf_we asserts once in WB; total 8 cycles.
- SW with immediate ack → dmem_we=1 in MEM; WB has rf_we=0, pc_we=1.
- BEQ with br_taken=1 → pc_sel=1 in WB. With br_taken=0 → pc_sel=0.
- dec_is_halt in DECODE → halted=1 from the next cycle. Later imem_ack pulses cause no strobes. rst returns state to 0.
- TIMEOUT=4 with imem_ack held low → HALT and bus_err=1 after 4 FETCH cycles. rst asserted mid-MEM drops dmem_req in the same cycle.

Source files
------------

// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer.
// Holds the common enable/disable levels, the sequencer state encodings and
// the PC source select codes used by cpu_seq_ctrl and its helpers.
package cpu_seq_ctrl_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned SEQ_STATE_W = 3;

  // Codes 6 and 7 are unused and recover to SEQ_FETCH.
  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_MEM    = 3'd3,
    SEQ_WB     = 3'd4,
    SEQ_HALT   = 3'd5
  } seq_state_e;

  localparam logic PC_SEL_SEQ = 1'b0;  // PC + 4
  localparam logic PC_SEL_TGT = 1'b1;  // ALU branch/jump target

endpackage

// File: rtl/cpu_seq_ctrl_seq_timeout.sv
// Bus wait watchdog for the sequencer.
// Counts consecutive cycles spent waiting for an acknowledge and flags expiry
// on the cycle the count has reached TIMEOUT-1 with still no acknowledge.
// TIMEOUT = 0 disables expiry entirely.
// Ports:
//   clk     - core clock
//   rst     - synchronous active-high reset
//   waiting - sequencer is in a state that waits for an acknowledge
//   ack     - the acknowledge relevant to the current state
//   expired - wait budget used up this cycle
module seq_timeout #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic ack,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (TIMEOUT != 0) && waiting && !ack && (cnt_q == LIMIT);

  // Leaving a wait state only happens on ack or expiry, so clearing on those
  // (and whenever not waiting) also covers every state change.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!waiting || ack || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control FSM for the single-issue RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB and parks in
// HALT on a halt instruction or a bus timeout.
// Optional feature: define CPU_SEQ_PERF_CNT_EN to add cycle_cnt/instret_cnt.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   imem_req / imem_ack      - instruction fetch handshake
//   ir_we                    - latch fetched word into IR
//   dec_reg_we, dec_is_load, dec_is_store, dec_is_halt - decoder flags
//   br_taken                 - branch/jump redirect from the ALU
//   pc_we, pc_sel            - PC update strobe and source select
//   dmem_req, dmem_we / dmem_ack - data memory handshake
//   rf_we                    - register-file write strobe
//   halted, bus_err          - parked, and parked because of a timeout
//   state                    - current state (debug)
//   cycle_cnt, instret_cnt   - perf counters (CPU_SEQ_PERF_CNT_EN only)
module cpu_seq_ctrl
  import cpu_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  input  logic             dec_reg_we,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_halt,
  input  logic             br_taken,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             halted,
  output logic             bus_err,
  output logic [2:0]       state
`ifdef CPU_SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  seq_state_e state_q, state_d;
  logic       bus_err_q;
  logic       waiting;
  logic       wait_ack;
  logic       to_expired;

  assign waiting  = (state_q == SEQ_FETCH) || (state_q == SEQ_MEM);
  assign wait_ack = (state_q == SEQ_FETCH) ? imem_ack : dmem_ack;

  seq_timeout #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_seq_timeout (
    .clk     (clk),
    .rst     (rst),
    .waiting (waiting),
    .ack     (wait_ack),
    .expired (to_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_FETCH: begin
        if (to_expired)    state_d = SEQ_HALT;
        else if (imem_ack) state_d = SEQ_DECODE;
      end
      SEQ_DECODE: state_d = dec_is_halt ? SEQ_HALT : SEQ_EXEC;
      SEQ_EXEC:   state_d = (dec_is_load || dec_is_store) ? SEQ_MEM : SEQ_WB;
      SEQ_MEM: begin
        if (to_expired)    state_d = SEQ_HALT;
        else if (dmem_ack) state_d = SEQ_WB;
      end
      SEQ_WB:     state_d = SEQ_FETCH;
      SEQ_HALT:   state_d = SEQ_HALT;
      default:    state_d = SEQ_FETCH;
    endcase
  end

  // Outputs decode the state register only; reset masks them immediately so
  // any outstanding request drops in the cycle rst is raised.
  always_comb begin
    imem_req = DISABLE;
    ir_we    = DISABLE;
    pc_we    = DISABLE;
    pc_sel   = PC_SEL_SEQ;
    dmem_req = DISABLE;
    dmem_we  = DISABLE;
    rf_we    = DISABLE;
    halted   = DISABLE;
    state    = '0;
    if (!rst) begin
      state = state_q;
      case (state_q)
        SEQ_FETCH: begin
          imem_req = ENABLE;
          ir_we    = imem_ack;
        end
        SEQ_MEM: begin
          dmem_req = ENABLE;
          dmem_we  = dec_is_store;
        end
        SEQ_WB: begin
          pc_we  = ENABLE;
          pc_sel = br_taken ? PC_SEL_TGT : PC_SEL_SEQ;
          rf_we  = dec_reg_we;
        end
        SEQ_HALT: halted = ENABLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEQ_FETCH;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (to_expired) bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != SEQ_HALT) cycle_q <= cycle_q + CNT_W'(1);
      if (state_q == SEQ_WB)   instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl. Two instances share the stimulus: one with
// the timeout disabled and one with TIMEOUT=4. Each step drives inputs on the
// falling edge and compares both instances shortly after.
module tb_cpu_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;
  logic dec_reg_we = 1'b0, dec_is_load = 1'b0, dec_is_store = 1'b0;
  logic dec_is_halt = 1'b0, br_taken = 1'b0;

  logic       imem_req0, ir_we0, pc_we0, pc_sel0, dmem_req0, dmem_we0, rf_we0;
  logic       halted0, bus_err0;
  logic [2:0] state0;
  logic       imem_req4, ir_we4, pc_we4, pc_sel4, dmem_req4, dmem_we4, rf_we4;
  logic       halted4, bus_err4;
  logic [2:0] state4;
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] cyc0, ret0, cyc4, ret4;
`endif

  cpu_seq_ctrl #(.CNT_W(32), .TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req0), .imem_ack(imem_ack), .ir_we(ir_we0),
    .dec_reg_we(dec_reg_we), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_halt(dec_is_halt), .br_taken(br_taken), .pc_we(pc_we0), .pc_sel(pc_sel0),
    .dmem_req(dmem_req0), .dmem_we(dmem_we0), .dmem_ack(dmem_ack), .rf_we(rf_we0),
    .halted(halted0), .bus_err(bus_err0), .state(state0)
`ifdef CPU_SEQ_PERF_CNT_EN
    , .cycle_cnt(cyc0), .instret_cnt(ret0)
`endif
  );

  cpu_seq_ctrl #(.CNT_W(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .imem_req(imem_req4), .imem_ack(imem_ack), .ir_we(ir_we4),
    .dec_reg_we(dec_reg_we), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_halt(dec_is_halt), .br_taken(br_taken), .pc_we(pc_we4), .pc_sel(pc_sel4),
    .dmem_req(dmem_req4), .dmem_we(dmem_we4), .dmem_ack(dmem_ack), .rf_we(rf_we4),
    .halted(halted4), .bus_err(bus_err4), .state(state4)
`ifdef CPU_SEQ_PERF_CNT_EN
    , .cycle_cnt(cyc4), .instret_cnt(ret4)
`endif
  );

  // Packed observation: {state, imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, rf_we,
  // halted, bus_err}
  logic [11:0] act0, act4;
  assign act0 = {state0, imem_req0, ir_we0, pc_we0, pc_sel0, dmem_req0, dmem_we0, rf_we0,
                 halted0, bus_err0};
  assign act4 = {state4, imem_req4, ir_we4, pc_we4, pc_sel4, dmem_req4, dmem_we4, rf_we4,
                 halted4, bus_err4};

  // Input bits: {rst, imem_ack, dmem_ack, dec_reg_we, load, store, halt, br_taken}
  localparam logic [7:0] I_RST = 8'h80, I_IACK = 8'h40, I_DACK = 8'h20, I_RWE = 8'h10;
  localparam logic [7:0] I_LD  = 8'h08, I_ST   = 8'h04, I_HLT  = 8'h02, I_BR  = 8'h01;
  localparam logic [8:0] O_IREQ = 9'h100, O_IRWE = 9'h080, O_PCWE = 9'h040;
  localparam logic [8:0] O_PCSEL = 9'h020, O_DREQ = 9'h010, O_DWE = 9'h008;
  localparam logic [8:0] O_RFWE = 9'h004, O_HLTD = 9'h002, O_BERR = 9'h001;

  typedef struct {
    string       name;
    logic [7:0]  in;
    logic [11:0] exp0;
    logic [11:0] exp4;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [11:0] e(input logic [2:0] st, input logic [8:0] fl);
    return {st, fl};
  endfunction

  task automatic add(input string name, input logic [7:0] in, input logic [11:0] exp);
    vec_t v;
    v.name = name; v.in = in; v.exp0 = exp; v.exp4 = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input logic [7:0] in, input logic [11:0] exp0,
                      input logic [11:0] exp4);
    @(negedge clk);
    {rst, imem_ack, dmem_ack, dec_reg_we, dec_is_load, dec_is_store, dec_is_halt,
     br_taken} = in;
    #1;
    chk({name, "/to0"}, 64'(act0), 64'(exp0));
    chk({name, "/to4"}, 64'(act4), 64'(exp4));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    add("rst0", I_RST, e(0, 0));
    add("rst1", I_RST, e(0, 0));
    add("addi_f", I_IACK | I_RWE, e(0, O_IREQ | O_IRWE));
    add("addi_d", I_RWE, e(1, 0));
    add("addi_x", I_RWE, e(2, 0));
    add("addi_w", I_RWE, e(4, O_PCWE | O_RFWE));
    add("lw_f", I_IACK | I_RWE | I_LD, e(0, O_IREQ | O_IRWE));
    add("lw_d", I_RWE | I_LD, e(1, 0));
    add("lw_x", I_RWE | I_LD, e(2, 0));
    add("lw_m0", I_RWE | I_LD | I_IACK, e(3, O_DREQ));
    add("lw_m1", I_RWE | I_LD, e(3, O_DREQ));
    add("lw_m2", I_RWE | I_LD, e(3, O_DREQ));
    add("lw_m3", I_RWE | I_LD | I_DACK, e(3, O_DREQ));
    add("lw_w", I_RWE | I_LD, e(4, O_PCWE | O_RFWE));
    add("sw_f", I_IACK | I_ST, e(0, O_IREQ | O_IRWE));
    add("sw_d", I_ST, e(1, 0));
    add("sw_x", I_ST, e(2, 0));
    add("sw_m", I_ST | I_DACK, e(3, O_DREQ | O_DWE));
    add("sw_w", I_ST, e(4, O_PCWE));
    add("beq_fw", I_DACK | I_BR, e(0, O_IREQ));
    add("beq_f", I_IACK | I_BR, e(0, O_IREQ | O_IRWE));
    add("beq_d", I_BR, e(1, 0));
    add("beq_x", I_BR | I_DACK, e(2, 0));
    add("beq_w", I_BR, e(4, O_PCWE | O_PCSEL));
    add("bne_f", I_IACK, e(0, O_IREQ | O_IRWE));
    add("bne_d", 8'h00, e(1, 0));
    add("bne_x", 8'h00, e(2, 0));
    add("bne_w", 8'h00, e(4, O_PCWE));
    add("hlt_f", I_IACK | I_HLT, e(0, O_IREQ | O_IRWE));
    add("hlt_d", I_HLT, e(1, 0));
    add("hlt_h0", I_IACK, e(5, O_HLTD));
    add("hlt_h1", I_IACK | I_DACK, e(5, O_HLTD));
    add("hlt_rst", I_RST | I_IACK, e(0, 0));
    add("hlt_rel", 8'h00, e(0, O_IREQ));
    add("rm_f", I_IACK | I_LD | I_RWE, e(0, O_IREQ | O_IRWE));
    add("rm_d", I_LD | I_RWE, e(1, 0));
    add("rm_x", I_LD | I_RWE, e(2, 0));
    add("rm_m", I_LD | I_RWE, e(3, O_DREQ));
    add("rm_rst", I_RST | I_LD | I_RWE, e(0, 0));
    add("rm_rel", 8'h00, e(0, O_IREQ));

    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp0, vecs[i].exp4);

    // Fetch timeout: four waiting FETCH cycles, then HALT with bus_err on dut_to only.
    step("tf_rst", I_RST, e(0, 0), e(0, 0));
    for (int i = 0; i < 4; i++) step("tf_wait", 8'h00, e(0, O_IREQ), e(0, O_IREQ));
    step("tf_exp0", 8'h00, e(0, O_IREQ), e(5, O_HLTD | O_BERR));
    step("tf_exp1", 8'h00, e(0, O_IREQ), e(5, O_HLTD | O_BERR));
    step("tf_late", I_IACK, e(0, O_IREQ | O_IRWE), e(5, O_HLTD | O_BERR));
    step("tf_rst2", I_RST, e(0, 0), e(0, O_BERR));
    step("tf_rel", 8'h00, e(0, O_IREQ), e(0, O_IREQ));

    // Data timeout: load with dmem_ack withheld past the budget.
    step("tm_f", I_IACK | I_LD | I_RWE, e(0, O_IREQ | O_IRWE), e(0, O_IREQ | O_IRWE));
    step("tm_d", I_LD | I_RWE, e(1, 0), e(1, 0));
    step("tm_x", I_LD | I_RWE, e(2, 0), e(2, 0));
    for (int i = 0; i < 4; i++) step("tm_wait", I_LD | I_RWE, e(3, O_DREQ), e(3, O_DREQ));
    step("tm_exp", I_LD | I_RWE | I_DACK, e(3, O_DREQ), e(5, O_HLTD | O_BERR));
    step("tm_wb", I_LD | I_RWE, e(4, O_PCWE | O_RFWE), e(5, O_HLTD | O_BERR));
    step("tm_rst", I_RST, e(0, 0), e(0, O_BERR));

`ifdef CPU_SEQ_PERF_CNT_EN
    step("pc_rst", I_RST, e(0, 0), e(0, 0));
    step("pc_f", I_IACK | I_RWE, e(0, O_IREQ | O_IRWE), e(0, O_IREQ | O_IRWE));
    step("pc_d", I_RWE, e(1, 0), e(1, 0));
    step("pc_x", I_RWE, e(2, 0), e(2, 0));
    step("pc_w", I_RWE, e(4, O_PCWE | O_RFWE), e(4, O_PCWE | O_RFWE));
    step("pc_hf", I_IACK | I_HLT, e(0, O_IREQ | O_IRWE), e(0, O_IREQ | O_IRWE));
    chk("perf_after_addi", {cyc0, ret0}, {32'd4, 32'd1});
    step("pc_hd", I_HLT, e(1, 0), e(1, 0));
    step("pc_h0", 8'h00, e(5, O_HLTD), e(5, O_HLTD));
    step("pc_h1", 8'h00, e(5, O_HLTD), e(5, O_HLTD));
    chk("perf_frozen", {cyc0, ret0}, {32'd6, 32'd1});
    chk("perf_frozen_to", {cyc4, ret4}, {32'd6, 32'd1});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
